axil_req_arbiter: RTL and testbench

AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter

---
 rtl/axil_req_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_axil_req_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_req_arbiter.sv
// Two-requester round-robin front end onto a single AXI4-Lite master port.
// One transaction is in flight at a time; completion is a one-cycle ack pulse.
module axil_req_arbiter #(
    parameter int unsigned C_ADDR_WIDTH = 4,
    parameter int unsigned C_DATA_WIDTH = 32
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [1:0]                  req,
    input  logic [1:0]                  we,
    input  logic [2*C_ADDR_WIDTH-1:0]   addr,
    input  logic [2*C_DATA_WIDTH-1:0]   wdata,
    output logic [1:0]                  ack,
    output logic [C_DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                  resp,
    output logic [C_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [C_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    localparam int unsigned STRB_W = C_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_q, last_d;
    logic                    pick;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [1:0]              ack_q, ack_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;

    // Next state, captured request and next values of every registered output
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack_d     = 2'b00;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        // On a tie the requester not served last wins; otherwise the lone requester
        pick      = (req == 2'b11) ? ~last_q : req[1];

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_d = pick;
                    last_d  = pick;
                    addr_d  = pick ? addr[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH] : addr[C_ADDR_WIDTH-1:0];
                    wdata_d = pick ? wdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH] : wdata[C_DATA_WIDTH-1:0];
                    if (we[pick]) begin
                        state_d   = WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                // A channel whose valid is already low has completed its handshake
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end
            end
            WR_B: begin
                if (m_axi_bvalid) begin
                    state_d        = DONE;
                    bready_d       = 1'b0;
                    resp_d         = m_axi_bresp;
                    ack_d[grant_q] = 1'b1;
                end
            end
            RD_AR: begin
                if (m_axi_arready) begin
                    state_d   = RD_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_R: begin
                if (m_axi_rvalid) begin
                    state_d        = DONE;
                    rready_d       = 1'b0;
                    rdata_d        = m_axi_rdata;
                    resp_d         = m_axi_rresp;
                    ack_d[grant_q] = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 ahead on the next tie
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 2'b00;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    assign ack           = ack_q;
    assign rdata         = rdata_q;
    assign resp          = resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = {STRB_W{1'b1}};
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Bench for axil_req_arbiter: two requester drivers, a randomized AXI4-Lite
// memory slave and a transaction-level reference model of arbitration and data.
module tb_axil_req_arbiter;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
    } op_t;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [1:0]  req, we, ack, resp;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    axil_req_arbiter #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .resp(resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester side
    op_t  q0[$], q1[$];
    op_t  cur[2];
    bit [1:0] active;
    int   p_load = 100;
    int   p_b2b  = 0;
    int   issue_step[2];

    // Slave side
    int   p_rdy = 100;
    int   w_lag = 0;
    bit   r_hold = 0;
    bit   err_en = 0;
    bit   aw_got, w_got, ar_got;
    logic [1:0]  aw_a, ar_a;
    logic [31:0] w_d;
    int   aw_age;
    logic [31:0] smem[4];
    bit   hs_aw, hs_w, hs_b, hs_ar, hs_r;
    int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [1:0]  sent_resp;
    bit   prev_awv, prev_wv, prev_arv;
    logic [3:0]  prev_awaddr, prev_araddr;
    logic [31:0] prev_wdata;
    int   wonly_cnt;

    // Reference model
    bit   busy, arb_open, arb_pend;
    bit   mlast, mg;
    op_t  mop;
    logic [31:0] ref_mem[4];
    logic [31:0] exp_rdata;
    int   ack_cnt, last_lat, stepn;
    int   ack_log[$];
    logic [31:0] rd_log[$];

    function automatic bit rnd(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic clear_slave();
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0;
        m_axi_rdata = 0;
        aw_got = 0; w_got = 0; ar_got = 0; aw_age = 0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        prev_awv = 0; prev_wv = 0; prev_arv = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    endtask

    task automatic drive_reqs();
        for (int n = 0; n < 2; n++) begin
            if (active[n]) begin
                req[n] = 1'b1; we[n] = cur[n].we;
                addr[n*4 +: 4] = cur[n].addr; wdata[n*32 +: 32] = cur[n].data;
            end else begin
                req[n] = 1'b0; we[n] = 1'($urandom);
                addr[n*4 +: 4] = 4'($urandom); wdata[n*32 +: 32] = $urandom;
            end
        end
    endtask

    // One clock of bench activity, evaluated between active edges
    task automatic step();
        bit r_aw, r_w, r_b, r_ar, r_r, acked;
        bit ag;
        logic [1:0] e_ack;
        op_t nop;
        @(negedge ACLK);
        stepn++;
        if (arb_pend) begin arb_open = 1; arb_pend = 0; end
        r_aw = hs_aw; r_w = hs_w; r_b = hs_b; r_ar = hs_ar; r_r = hs_r;
        acked = 0; ag = 0;

        // valid signals must hold until accepted, and drop right after
        if (prev_awv && !r_aw) begin
            check("aw_hold", m_axi_awvalid, 1); check("awaddr_hold", m_axi_awaddr, prev_awaddr);
        end
        if (prev_wv && !r_w) begin
            check("w_hold", m_axi_wvalid, 1); check("wdata_hold", m_axi_wdata, prev_wdata);
        end
        if (prev_arv && !r_ar) begin
            check("ar_hold", m_axi_arvalid, 1); check("araddr_hold", m_axi_araddr, prev_araddr);
        end
        if (r_aw) check("aw_drop", m_axi_awvalid, 0);
        if (r_w)  check("w_drop", m_axi_wvalid, 0);
        if (r_ar) check("ar_drop", m_axi_arvalid, 0);

        // retire handshakes that completed on the edge just passed
        if (aw_got && !r_aw) aw_age++;
        if (r_aw) begin aw_got = 1; aw_age = 1; aw_cnt++; end
        if (r_w)  begin w_got = 1; w_cnt++; end
        if (r_b)  begin m_axi_bvalid = 0; b_cnt++; end
        if (r_ar) begin ar_got = 1; ar_cnt++; end
        if (r_r)  begin m_axi_rvalid = 0; r_cnt++; end

        // completion
        if (ack != 2'b00) begin
            if (!busy) begin
                check("ack_unexpected", ack, 0);
            end else begin
                e_ack = mg ? 2'b10 : 2'b01;
                check("ack_bit", ack, e_ack);
                check("resp", resp, sent_resp);
                if (mop.we) begin
                    ref_mem[mop.addr[3:2]] = mop.data;
                    check("aw_count", aw_cnt, 1); check("w_count", w_cnt, 1);
                    check("b_count", b_cnt, 1);   check("ar_count", ar_cnt, 0);
                end else begin
                    exp_rdata = ref_mem[mop.addr[3:2]];
                    check("ar_count", ar_cnt, 1); check("r_count", r_cnt, 1);
                    check("aw_count", aw_cnt, 0);
                    rd_log.push_back(rdata);
                end
                check("rdata", rdata, exp_rdata);
                ack_log.push_back(int'(mg));
                last_lat = stepn - issue_step[mg];
                ack_cnt++;
                busy = 0; arb_pend = 1; active[mg] = 0; acked = 1; ag = mg;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end
        end

        if (!busy)
            check("idle_quiet", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
        else
            check("wrong_channel", mop.we ? m_axi_arvalid : (m_axi_awvalid | m_axi_wvalid), 0);
        if (m_axi_wvalid && !m_axi_awvalid) wonly_cnt++;

        // slave drive
        m_axi_awready = m_axi_awvalid && !aw_got && rnd(p_rdy);
        m_axi_wready  = m_axi_wvalid && !w_got &&
                        ((w_lag == 0) ? rnd(p_rdy) : (aw_got && aw_age >= w_lag));
        m_axi_arready = m_axi_arvalid && !ar_got && rnd(p_rdy);
        if (!m_axi_bvalid) m_axi_bresp = 2'($urandom);
        if (!m_axi_rvalid) begin m_axi_rresp = 2'($urandom); m_axi_rdata = $urandom; end
        if (!m_axi_bvalid && aw_got && w_got && rnd(p_rdy)) begin
            smem[aw_a] = w_d;
            m_axi_bvalid = 1;
            m_axi_bresp = err_en ? 2'($urandom_range(0, 3)) : 2'b00;
            sent_resp = m_axi_bresp;
            aw_got = 0; w_got = 0;
        end
        if (!m_axi_rvalid && ar_got && !r_hold && rnd(p_rdy)) begin
            m_axi_rvalid = 1;
            m_axi_rdata = smem[ar_a];
            m_axi_rresp = err_en ? 2'($urandom_range(0, 3)) : 2'b00;
            sent_resp = m_axi_rresp;
            ar_got = 0;
        end

        // handshakes that the next edge will complete
        hs_aw = m_axi_awvalid && m_axi_awready;
        hs_w  = m_axi_wvalid && m_axi_wready;
        hs_b  = m_axi_bvalid && m_axi_bready;
        hs_ar = m_axi_arvalid && m_axi_arready;
        hs_r  = m_axi_rvalid && m_axi_rready;
        if (hs_aw) begin aw_a = m_axi_awaddr[3:2]; check("awaddr", m_axi_awaddr, mop.addr); end
        if (hs_w) begin
            w_d = m_axi_wdata;
            check("wdata", m_axi_wdata, mop.data); check("wstrb", m_axi_wstrb, 4'hF);
        end
        if (hs_ar) begin ar_a = m_axi_araddr[3:2]; check("araddr", m_axi_araddr, mop.addr); end
        prev_awv = m_axi_awvalid; prev_wv = m_axi_wvalid; prev_arv = m_axi_arvalid;
        prev_awaddr = m_axi_awaddr; prev_wdata = m_axi_wdata; prev_araddr = m_axi_araddr;

        // requesters: hold until ack, then either drop or re-request at once
        for (int n = 0; n < 2; n++) begin
            if (!active[n] && !(acked && ag == 1'(n) && !rnd(p_b2b)) && rnd(p_load)) begin
                if (n == 0 && q0.size() > 0) begin
                    nop = q0.pop_front(); cur[0] = nop; active[0] = 1; issue_step[0] = stepn;
                end else if (n == 1 && q1.size() > 0) begin
                    nop = q1.pop_front(); cur[1] = nop; active[1] = 1; issue_step[1] = stepn;
                end
            end
        end
        drive_reqs();

        // arbitration: lone requester wins; a tie goes to the one not served last
        if (arb_open && req != 2'b00) begin
            mg = (req == 2'b11) ? !mlast : req[1];
            mlast = mg; mop = cur[mg]; busy = 1; arb_open = 0;
        end
    endtask

    task automatic check_zero(input string p);
        check({p, "_ack"}, ack, 0);       check({p, "_rdata"}, rdata, 0);
        check({p, "_resp"}, resp, 0);     check({p, "_awvalid"}, m_axi_awvalid, 0);
        check({p, "_wvalid"}, m_axi_wvalid, 0); check({p, "_bready"}, m_axi_bready, 0);
        check({p, "_arvalid"}, m_axi_arvalid, 0); check({p, "_rready"}, m_axi_rready, 0);
        check({p, "_awaddr"}, m_axi_awaddr, 0); check({p, "_wdata"}, m_axi_wdata, 0);
        check({p, "_araddr"}, m_axi_araddr, 0);
    endtask

    task automatic do_reset(input string p);
        @(negedge ACLK);
        ARESET = 1; active = 0; drive_reqs(); clear_slave();
        @(negedge ACLK);
        check_zero({p, "_in"});
        ARESET = 0;
        busy = 0; arb_open = 1; arb_pend = 0; mlast = 1; exp_rdata = 0;
        @(negedge ACLK);
        check_zero({p, "_out"});
    endtask

    task automatic run_until_done(input int max_steps);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || active != 0 || busy) && n < max_steps) begin
            step(); n++;
        end
        if (n >= max_steps) check("timeout", 1, 0);
    endtask

    int exp_ord[4] = '{0, 1, 0, 1};
    int seen_rr;

    initial begin
        ARESET = 1; req = 0; we = 0; addr = 0; wdata = 0; active = 0;
        stepn = 0; ack_cnt = 0; wonly_cnt = 0; sent_resp = 0;
        for (int i = 0; i < 4; i++) begin smem[i] = 0; ref_mem[i] = 0; end
        clear_slave();
        do_reset("rst0");

        // Single write through a zero-wait slave
        q0.push_back('{1'b1, 4'h4, 32'h0000_00A5});
        run_until_done(50);
        check("t1_acks", ack_cnt, 1);
        // ack arrives in the 4th cycle, counting the first cycle req is seen as cycle 1
        check("t1_latency", last_lat, 3);
        check("t1_resp", resp, 0);

        // Both requesters continuously requesting from reset
        do_reset("rst1");
        p_b2b = 100; ack_log.delete();
        q0.push_back('{1'b0, 4'h0, 32'h0}); q0.push_back('{1'b0, 4'h0, 32'h0});
        q1.push_back('{1'b0, 4'h8, 32'h0}); q1.push_back('{1'b0, 4'h8, 32'h0});
        run_until_done(100);
        check("t2_ack_count", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) check("t2_order", ack_log[i], exp_ord[i]);
        p_b2b = 0;

        // Write data accepted three cycles after the address
        w_lag = 3; wonly_cnt = 0;
        q0.push_back('{1'b1, 4'h8, 32'h1234_5678});
        run_until_done(60);
        check("t3_w_only_cycles", wonly_cnt, 3);
        w_lag = 0;

        // Fill all four words then read them back
        rd_log.delete();
        for (int i = 0; i < 4; i++) q0.push_back('{1'b1, 4'(i * 4), 32'(i + 1)});
        for (int i = 0; i < 4; i++) q0.push_back('{1'b0, 4'(i * 4), 32'h0});
        run_until_done(200);
        check("t4_reads", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) check("t4_readback", rd_log[i], 32'(i + 1));
        check("t4_resp", resp, 0);

        // Reset while waiting for read data
        r_hold = 1; seen_rr = 0;
        q0.push_back('{1'b0, 4'h8, 32'h0});
        for (int i = 0; i < 20 && !seen_rr; i++) begin
            step();
            if (m_axi_rready) seen_rr = 1;
        end
        check("t5_reached_rd_r", seen_rr, 1);
        do_reset("rst2");
        r_hold = 0;
        for (int i = 0; i < 3; i++) begin step(); check("t5_no_ack", ack, 0); end
        ack_cnt = 0;
        q0.push_back('{1'b0, 4'h8, 32'h0});
        run_until_done(50);
        check("t5_recover_acks", ack_cnt, 1);

        // Random traffic, random slave timing and error responses
        err_en = 1; p_rdy = 60; p_load = 40; p_b2b = 50;
        for (int i = 0; i < 60; i++) begin
            q0.push_back('{1'($urandom), 4'($urandom_range(0, 3) * 4), $urandom});
            q1.push_back('{1'($urandom), 4'($urandom_range(0, 3) * 4), $urandom});
        end
        ack_cnt = 0;
        run_until_done(20000);
        check("t6_acks", ack_cnt, 120);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
